// File: rtl/vector_lsu_if.sv
// Data-memory bus between vector_lsu and its memory.
// One single-beat valid/ready channel for reads and one for writes.
// master: the load/store unit; slave: the data memory.
interface vector_lsu_if #(
    parameter int DATA_BITS = 8,
    parameter int ADDR_BITS = 8
) ();
    logic                 mem_read_valid;
    logic [ADDR_BITS-1:0] mem_read_address;
    logic                 mem_read_ready;
    logic [DATA_BITS-1:0] mem_read_data;
    logic                 mem_write_valid;
    logic [ADDR_BITS-1:0] mem_write_address;
    logic [DATA_BITS-1:0] mem_write_data;
    logic                 mem_write_ready;

    modport master (
        output mem_read_valid,
        output mem_read_address,
        input  mem_read_ready,
        input  mem_read_data,
        output mem_write_valid,
        output mem_write_address,
        output mem_write_data,
        input  mem_write_ready
    );

    modport slave (
        input  mem_read_valid,
        input  mem_read_address,
        output mem_read_ready,
        output mem_read_data,
        input  mem_write_valid,
        input  mem_write_address,
        input  mem_write_data,
        output mem_write_ready
    );
endinterface

// File: rtl/vector_lsu.sv
// vector_lsu: per-thread load/store unit for scalar LDR/STR and
// VECTOR_SIZE-lane vector loads/stores (gather/scatter or base+stride,
// with a per-lane mask). Lanes are serviced one at a time, each active
// lane issuing a single-beat transaction on the memory interface.
//
// Optional build macro LSU_TIMEOUT_EN: adds a per-beat WAITING timeout of
// TIMEOUT_CYCLES cycles that aborts the access and raises lsu_error.
// Without it, WAITING waits forever and lsu_error is constant 0.
module vector_lsu #(
    parameter int VECTOR_SIZE    = 4,
    parameter int DATA_BITS      = 8,
    parameter int ADDR_BITS      = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             enable,
    input  logic [2:0]                       core_state,
    input  logic                             decoded_mem_read_enable,
    input  logic                             decoded_mem_write_enable,
    input  logic                             decoded_vector_mux,
    input  logic                             decoded_stride_mode,
    input  logic [VECTOR_SIZE-1:0]           lane_mask,
    input  logic [DATA_BITS-1:0]             rs,
    input  logic [DATA_BITS-1:0]             rt,
    input  logic [VECTOR_SIZE*DATA_BITS-1:0] v_rs,
    input  logic [VECTOR_SIZE*DATA_BITS-1:0] v_rt,
    vector_lsu_if.master                     mem,
    output logic [2:0]                       lsu_state,
    output logic [DATA_BITS-1:0]             lsu_out,
    output logic [VECTOR_SIZE*DATA_BITS-1:0] v_lsu_out,
    output logic                             lsu_error
);

    localparam int LANE_BITS = $clog2(VECTOR_SIZE);
    localparam logic [2:0] CORE_REQUEST = 3'b011;
    localparam logic [2:0] CORE_UPDATE  = 3'b110;
    localparam logic [LANE_BITS-1:0] LAST_LANE = LANE_BITS'(VECTOR_SIZE - 1);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_REQUESTING = 3'd1,
        ST_WAITING    = 3'd2,
        ST_NEXT       = 3'd3,
        ST_DONE       = 3'd4
    } lsu_state_t;

    // Registered state and outputs
    lsu_state_t                       state_r;
    logic [LANE_BITS-1:0]             lane_r;
    logic                             rd_valid_r;
    logic [ADDR_BITS-1:0]             rd_addr_r;
    logic                             wr_valid_r;
    logic [ADDR_BITS-1:0]             wr_addr_r;
    logic [DATA_BITS-1:0]             wr_data_r;
    logic [DATA_BITS-1:0]             lsu_out_r;
    logic [VECTOR_SIZE*DATA_BITS-1:0] v_lsu_out_r;

    // Next-state values
    lsu_state_t                       state_s;
    logic [LANE_BITS-1:0]             lane_s;
    logic                             rd_valid_s;
    logic [ADDR_BITS-1:0]             rd_addr_s;
    logic                             wr_valid_s;
    logic [ADDR_BITS-1:0]             wr_addr_s;
    logic [DATA_BITS-1:0]             wr_data_s;
    logic [DATA_BITS-1:0]             lsu_out_s;
    logic [VECTOR_SIZE*DATA_BITS-1:0] v_lsu_out_s;

`ifdef LSU_TIMEOUT_EN
    localparam int TMO_BITS = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_BITS-1:0] TMO_LAST = TMO_BITS'(TIMEOUT_CYCLES - 1);
    logic                err_r;
    logic                err_s;
    logic [TMO_BITS-1:0] tmo_cnt_r;
    logic [TMO_BITS-1:0] tmo_cnt_s;
`endif

    // Request decode: a load wins when both enables are set
    logic                 is_read_s;
    logic                 is_write_s;
    logic                 lane_active_s;
    logic [DATA_BITS-1:0] lane_vrs_s;
    logic [DATA_BITS-1:0] lane_vrt_s;
    logic [ADDR_BITS-1:0] stride_addr_s;
    logic [ADDR_BITS-1:0] req_addr_s;
    logic [DATA_BITS-1:0] req_data_s;

    assign is_read_s     = decoded_mem_read_enable;
    assign is_write_s    = decoded_mem_write_enable & ~decoded_mem_read_enable;
    assign lane_active_s = lane_mask[lane_r];
    assign lane_vrs_s    = v_rs[int'(lane_r) * DATA_BITS +: DATA_BITS];
    assign lane_vrt_s    = v_rt[int'(lane_r) * DATA_BITS +: DATA_BITS];
    // Strided address wraps modulo the address space
    assign stride_addr_s = ADDR_BITS'(rs) + ADDR_BITS'(lane_r) * ADDR_BITS'(rt);

    // Select address and store data for the current beat
    always_comb begin
        req_addr_s = ADDR_BITS'(rs);
        req_data_s = rt;
        if (decoded_vector_mux) begin
            req_data_s = lane_vrt_s;
            if (decoded_stride_mode) begin
                req_addr_s = stride_addr_s;
            end else begin
                req_addr_s = ADDR_BITS'(lane_vrs_s);
            end
        end else begin
            req_addr_s = ADDR_BITS'(rs);
            req_data_s = rt;
        end
    end

    // Sequencer next-state and datapath updates; everything holds while enable is low
    always_comb begin
        state_s     = state_r;
        lane_s      = lane_r;
        rd_valid_s  = rd_valid_r;
        rd_addr_s   = rd_addr_r;
        wr_valid_s  = wr_valid_r;
        wr_addr_s   = wr_addr_r;
        wr_data_s   = wr_data_r;
        lsu_out_s   = lsu_out_r;
        v_lsu_out_s = v_lsu_out_r;
`ifdef LSU_TIMEOUT_EN
        err_s       = err_r;
        tmo_cnt_s   = tmo_cnt_r;
`endif
        if (enable) begin
            case (state_r)
                ST_IDLE: begin
                    if ((core_state == CORE_REQUEST) &&
                        (decoded_mem_read_enable || decoded_mem_write_enable)) begin
                        state_s = ST_REQUESTING;
                        lane_s  = '0;
`ifdef LSU_TIMEOUT_EN
                        err_s   = 1'b0;
`endif
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_REQUESTING: begin
                    if (!decoded_vector_mux || lane_active_s) begin
                        rd_valid_s = is_read_s;
                        wr_valid_s = is_write_s;
                        if (is_read_s) begin
                            rd_addr_s = req_addr_s;
                        end else begin
                            wr_addr_s = req_addr_s;
                            wr_data_s = req_data_s;
                        end
`ifdef LSU_TIMEOUT_EN
                        tmo_cnt_s = '0;
`endif
                        state_s = ST_WAITING;
                    end else begin
                        // masked lane: no traffic, its result slot is left untouched
                        state_s = ST_NEXT;
                    end
                end
                ST_WAITING: begin
                    if (rd_valid_r && mem.mem_read_ready) begin
                        rd_valid_s = 1'b0;
                        if (decoded_vector_mux) begin
                            v_lsu_out_s[int'(lane_r) * DATA_BITS +: DATA_BITS] = mem.mem_read_data;
                            state_s = ST_NEXT;
                        end else begin
                            lsu_out_s = mem.mem_read_data;
                            state_s   = ST_DONE;
                        end
                    end else if (wr_valid_r && mem.mem_write_ready) begin
                        wr_valid_s = 1'b0;
                        state_s    = decoded_vector_mux ? ST_NEXT : ST_DONE;
                    end else if (!rd_valid_r && !wr_valid_r) begin
                        // no beat outstanding (enables dropped mid-access): move on rather than hang
                        state_s = decoded_vector_mux ? ST_NEXT : ST_DONE;
                    end else begin
`ifdef LSU_TIMEOUT_EN
                        if (tmo_cnt_r == TMO_LAST) begin
                            // abort: drop the beat, skip remaining lanes, capture nothing
                            rd_valid_s = 1'b0;
                            wr_valid_s = 1'b0;
                            err_s      = 1'b1;
                            state_s    = ST_DONE;
                        end else begin
                            tmo_cnt_s = tmo_cnt_r + 1'b1;
                            state_s   = ST_WAITING;
                        end
`else
                        state_s = ST_WAITING;
`endif
                    end
                end
                ST_NEXT: begin
                    if (lane_r == LAST_LANE) begin
                        state_s = ST_DONE;
                    end else begin
                        lane_s  = lane_r + 1'b1;
                        state_s = ST_REQUESTING;
                    end
                end
                ST_DONE: begin
                    if (core_state == CORE_UPDATE) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_DONE;
                    end
                end
                default: begin
                    state_s    = ST_IDLE;
                    rd_valid_s = 1'b0;
                    wr_valid_s = 1'b0;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // State and output registers with asynchronous clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            lane_r      <= '0;
            rd_valid_r  <= 1'b0;
            rd_addr_r   <= '0;
            wr_valid_r  <= 1'b0;
            wr_addr_r   <= '0;
            wr_data_r   <= '0;
            lsu_out_r   <= '0;
            v_lsu_out_r <= '0;
`ifdef LSU_TIMEOUT_EN
            err_r       <= 1'b0;
            tmo_cnt_r   <= '0;
`endif
        end else begin
            state_r     <= state_s;
            lane_r      <= lane_s;
            rd_valid_r  <= rd_valid_s;
            rd_addr_r   <= rd_addr_s;
            wr_valid_r  <= wr_valid_s;
            wr_addr_r   <= wr_addr_s;
            wr_data_r   <= wr_data_s;
            lsu_out_r   <= lsu_out_s;
            v_lsu_out_r <= v_lsu_out_s;
`ifdef LSU_TIMEOUT_EN
            err_r       <= err_s;
            tmo_cnt_r   <= tmo_cnt_s;
`endif
        end
    end

    assign mem.mem_read_valid    = rd_valid_r;
    assign mem.mem_read_address  = rd_addr_r;
    assign mem.mem_write_valid   = wr_valid_r;
    assign mem.mem_write_address = wr_addr_r;
    assign mem.mem_write_data    = wr_data_r;
    assign lsu_state             = state_r;
    assign lsu_out               = lsu_out_r;
    assign v_lsu_out             = v_lsu_out_r;
`ifdef LSU_TIMEOUT_EN
    assign lsu_error             = err_r;
`else
    assign lsu_error             = 1'b0;
`endif

endmodule
